// File: rtl/mem_bus_pkg.sv
// Shared native memory bus definitions: widths, arbiter state encoding, timeout error data.
// No logic; latency and backpressure are defined by the modules that import it.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Counter must be able to hold the limit itself; a disabled (0) limit still gets one bit.
  function automatic int cnt_width(input int limit);
    return (limit <= 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating transaction timer; hit is combinational in the cycle whose increment reaches LIMIT.
// Latency 0 for hit; no backpressure, counts only while en, LIMIT=0 never hits.
module mem_arb_timer
  import mem_bus_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int CW    = cnt_width(LIMIT)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          hit
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (load_val > LIM) ? LIM : load_val;
    end else if (en && (cnt_q != LIM)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit = (LIMIT != 0) && en && (cnt_q == LIM - 1'b1);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter with per-transaction timeout for the native memory bus.
// Latency: 1 cycle valid->s_valid, 0 cycles s_ready->m_ready; masters hold requests until ready.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              grant,
  output logic              timeout_err
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  arb_state_t        state_q, state_d;
  logic              grant_q, last_q;
  logic              any_req, pick, busy, gvalid;
  logic              tmr_clr, tmr_en, tmr_hit;
  logic              done_ok, done_tmo, done;
  logic [DATA_W-1:0] done_rdata;

  assign any_req = m0_valid | m1_valid;
  // On a tie the master that did not complete most recently wins.
  assign pick    = (m0_valid & m1_valid) ? ~last_q : m1_valid;
  assign busy    = (state_q == ST_BUSY);
  assign gvalid  = grant_q ? m1_valid : m0_valid;

  assign tmr_clr = ~busy & any_req;
  assign tmr_en  = busy & ~s_ready;

  // tmr_hit is qualified by ~s_ready, so a same-cycle s_ready completes normally.
  assign done_ok  = busy & gvalid & s_ready;
  assign done_tmo = busy & gvalid & tmr_hit;
  assign done     = done_ok | done_tmo;

  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .CW    (CW)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ({CW{1'b0}}),
    .en       (tmr_en),
    .hit      (tmr_hit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (!busy && any_req) grant_q <= pick;
      if (done)             last_q  <= grant_q;
    end
  end

  // A granted master dropping valid mid-transaction aborts without completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_BUSY;
      ST_BUSY: if (!gvalid || done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    timeout_err = done_tmo;
    done_rdata  = done_tmo ? ERR_RDATA : s_rdata;
    if (busy) begin
      s_valid = gvalid & ~done_tmo;
      s_addr  = grant_q ? m1_addr  : m0_addr;
      s_wdata = grant_q ? m1_wdata : m0_wdata;
      s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
    end
    m0_ready = done & ~grant_q;
    m1_ready = done & grant_q;
    m0_rdata = m0_ready ? done_rdata : '0;
    m1_rdata = m1_ready ? done_rdata : '0;
  end

  assign grant = grant_q;

endmodule
